// File: rtl/reg_scoreboard.sv
// Register write scoreboard between ID and WB: per-register pending-write counters,
// a combinational issue-ready answer, a saturating stall counter and a sticky error flag.
module reg_scoreboard #(
    parameter int NUM_REGS = 32,
    parameter int ADDR_W   = 5,
    parameter int CNT_W    = 2,
    parameter int STALL_W  = 16
) (
    input  logic                i_CLK,
    input  logic                i_RSTn,
    input  logic                i_Issue_Valid,
    input  logic                i_Issue_RegWrite,
    input  logic [ADDR_W-1:0]   i_Issue_Dst,
    input  logic [ADDR_W-1:0]   i_Issue_Src1,
    input  logic                i_Issue_Src1_Used,
    input  logic [ADDR_W-1:0]   i_Issue_Src2,
    input  logic                i_Issue_Src2_Used,
    output logic                o_Issue_Ready,
    input  logic                i_WB_Valid,
    input  logic [ADDR_W-1:0]   i_WB_Dst,
    input  logic                i_Flush,
    output logic [NUM_REGS-1:0] o_Busy_Vec,
    output logic                o_Empty,
    output logic [STALL_W-1:0]  o_Stall_Cnt,
    output logic                o_Error
);

    localparam logic [CNT_W-1:0]   CNT_MAX   = '1;
    localparam logic [STALL_W-1:0] STALL_MAX = '1;

    function automatic logic [STALL_W-1:0] sat_inc(input logic [STALL_W-1:0] v);
        return (v == STALL_MAX) ? v : v + STALL_W'(1);
    endfunction

    logic [CNT_W-1:0]    cnt_q   [NUM_REGS];
    logic [CNT_W-1:0]    cnt_nxt [NUM_REGS];
    logic [NUM_REGS-1:0] busy;
    logic [NUM_REGS-1:0] inc_v;
    logic [NUM_REGS-1:0] dec_v;
    logic                haz_src1;
    logic                haz_src2;
    logic                dst_full;
    logic                ready;
    logic                accept;
    logic                err_set;
    logic [STALL_W-1:0]  stall_q;
    logic                err_q;

    // Hazard detection looks only at registered counts; a same-cycle WB does not bypass.
    always_comb begin
        haz_src1 = i_Issue_Src1_Used && (i_Issue_Src1 != '0) && (cnt_q[i_Issue_Src1] != '0);
        haz_src2 = i_Issue_Src2_Used && (i_Issue_Src2 != '0) && (cnt_q[i_Issue_Src2] != '0);
        dst_full = i_Issue_RegWrite && (i_Issue_Dst != '0) && (cnt_q[i_Issue_Dst] == CNT_MAX);
        ready    = !(haz_src1 || haz_src2 || dst_full);
        accept   = i_Issue_Valid && ready;
    end

    always_comb begin
        busy  = '0;
        inc_v = '0;
        dec_v = '0;
        for (int r = 1; r < NUM_REGS; r++) begin
            busy[r]  = (cnt_q[r] != '0);
            inc_v[r] = accept && i_Issue_RegWrite && (i_Issue_Dst == ADDR_W'(r));
            dec_v[r] = i_WB_Valid && (i_WB_Dst == ADDR_W'(r));
        end
    end

    // Next counts: flush wins; a matched increment/decrement pair leaves the count alone.
    always_comb begin
        for (int r = 0; r < NUM_REGS; r++) begin
            cnt_nxt[r] = cnt_q[r];
            if (i_Flush) begin
                cnt_nxt[r] = '0;
            end else if (inc_v[r] && !dec_v[r]) begin
                cnt_nxt[r] = cnt_q[r] + CNT_W'(1);
            end else if (dec_v[r] && !inc_v[r] && busy[r]) begin
                cnt_nxt[r] = cnt_q[r] - CNT_W'(1);
            end
        end
        cnt_nxt[0] = '0;
        err_set = !i_Flush && (|(dec_v & ~inc_v & ~busy));
    end

    always_ff @(posedge i_CLK or negedge i_RSTn) begin
        if (!i_RSTn) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                cnt_q[r] <= '0;
            end
            stall_q <= '0;
            err_q   <= 1'b0;
        end else begin
            cnt_q <= cnt_nxt;
            if (i_Issue_Valid && !ready) begin
                stall_q <= sat_inc(stall_q);
            end
            err_q <= err_q | err_set;
        end
    end

    assign o_Issue_Ready = ready;
    assign o_Busy_Vec    = busy;
    assign o_Empty       = ~|busy;
    assign o_Stall_Cnt   = stall_q;
    assign o_Error       = err_q;

endmodule
